// File: rtl/nts_rx_dispatcher_pkg.sv
// Shared types for the RX dispatcher: per-buffer states and write-FSM states.
package nts_rx_dispatcher_pkg;

  localparam int unsigned NUM_BUFS = 2;
  localparam int unsigned DATA_W   = 64;

  typedef enum logic [1:0] {
    BUF_FREE,
    BUF_FILLING,
    BUF_FULL,
    BUF_PRESENTED
  } buf_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_RECEIVE,
    WR_DROP
  } wr_state_e;

endpackage

// File: rtl/nts_rx_dispatcher_if.sv
// MAC RX input, engine dispatch port and drop counter of the RX dispatcher.
interface nts_rx_dispatcher_if;

  logic [7:0]  i_mac_rx_data_valid;
  logic [63:0] i_mac_rx_data;
  logic        i_mac_rx_good_frame;
  logic        i_mac_rx_bad_frame;
  logic        o_dispatch_packet_available;
  logic        i_dispatch_packet_read_discard;
  logic [7:0]  o_dispatch_data_valid;
  logic        o_dispatch_fifo_empty;
  logic        i_dispatch_fifo_rd_en;
  logic [63:0] o_dispatch_fifo_rd_data;
  logic [31:0] o_cnt_dropped;

  modport slave (
    input  i_mac_rx_data_valid, i_mac_rx_data, i_mac_rx_good_frame, i_mac_rx_bad_frame,
           i_dispatch_packet_read_discard, i_dispatch_fifo_rd_en,
    output o_dispatch_packet_available, o_dispatch_data_valid, o_dispatch_fifo_empty,
           o_dispatch_fifo_rd_data, o_cnt_dropped
  );

  modport master (
    output i_mac_rx_data_valid, i_mac_rx_data, i_mac_rx_good_frame, i_mac_rx_bad_frame,
           i_dispatch_packet_read_discard, i_dispatch_fifo_rd_en,
    input  o_dispatch_packet_available, o_dispatch_data_valid, o_dispatch_fifo_empty,
           o_dispatch_fifo_rd_data, o_cnt_dropped
  );

endinterface

// File: rtl/nts_rx_dispatcher_mem.sv
// Ping-pong frame store: two buffers of 2^ADDR_WIDTH x 64 bit, one write port, async read.
module nts_dispatcher_mem
  import nts_rx_dispatcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  wr_en_i,
  input  logic                  wr_buf_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_buf_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_BUFS * (2**ADDR_WIDTH)];

  always_ff @(posedge i_clk) begin
    if (wr_en_i) mem_q[{wr_buf_i, wr_addr_i}] <= wr_data_i;
  end

  assign rd_data_o = mem_q[{rd_buf_i, rd_addr_i}];

endmodule

// File: rtl/nts_rx_dispatcher.sv
// RX dispatcher: buffers whole good MAC frames in two ping-pong buffers and presents them to the engine.
module nts_rx_dispatcher
  import nts_rx_dispatcher_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input logic               i_clk,
  input logic               i_areset,
  nts_rx_dispatcher_if.slave bus
);

  typedef logic [ADDR_WIDTH:0] cnt_t;

  buf_state_e  buf_state_q [NUM_BUFS], buf_state_d [NUM_BUFS];
  cnt_t        count_q [NUM_BUFS], count_d [NUM_BUFS];
  logic [7:0]  last_valid_q [NUM_BUFS], last_valid_d [NUM_BUFS];
  wr_state_e   wr_state_q, wr_state_d;
  logic        wr_buf_q, wr_buf_d;
  cnt_t        wr_ptr_q, wr_ptr_d;
  logic        newest_q, newest_d;
  logic        rd_buf_q, rd_buf_d;
  cnt_t        rd_ptr_q, rd_ptr_d;
  logic [31:0] cnt_dropped_q, cnt_dropped_d;

  logic                  mem_we, mem_wsel;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_W-1:0]     mem_rdata;
  logic word, end_pulse, has_free, free_sel, full0, full1, present_sel;
  logic presented, empty;

  assign word      = |bus.i_mac_rx_data_valid;
  assign end_pulse = bus.i_mac_rx_good_frame | bus.i_mac_rx_bad_frame;
  assign has_free  = (buf_state_q[0] == BUF_FREE) || (buf_state_q[1] == BUF_FREE);
  assign free_sel  = (buf_state_q[0] != BUF_FREE);
  assign full0     = (buf_state_q[0] == BUF_FULL);
  assign full1     = (buf_state_q[1] == BUF_FULL);
  // Oldest FULL buffer: with both full, the one not committed most recently.
  assign present_sel = (full0 && full1) ? ~newest_q : full1;
  assign presented = (buf_state_q[rd_buf_q] == BUF_PRESENTED);
  assign empty     = !presented || (rd_ptr_q == count_q[rd_buf_q]);

  always_comb begin
    buf_state_d   = buf_state_q;
    count_d       = count_q;
    last_valid_d  = last_valid_q;
    wr_state_d    = wr_state_q;
    wr_buf_d      = wr_buf_q;
    wr_ptr_d      = wr_ptr_q;
    newest_d      = newest_q;
    rd_buf_d      = rd_buf_q;
    rd_ptr_d      = rd_ptr_q;
    cnt_dropped_d = cnt_dropped_q;
    mem_we        = 1'b0;
    mem_wsel      = wr_buf_q;
    mem_waddr     = wr_ptr_q[ADDR_WIDTH-1:0];

    unique case (wr_state_q)
      WR_IDLE: begin
        if (word) begin
          if (has_free) begin
            mem_we                 = 1'b1;
            mem_wsel               = free_sel;
            mem_waddr              = '0;
            wr_buf_d               = free_sel;
            wr_ptr_d               = cnt_t'(1);
            last_valid_d[free_sel] = bus.i_mac_rx_data_valid;
            buf_state_d[free_sel]  = BUF_FILLING;
            wr_state_d             = WR_RECEIVE;
          end else begin
            wr_state_d = WR_DROP;
          end
        end
      end
      WR_RECEIVE: begin
        if (word && wr_ptr_q[ADDR_WIDTH]) begin
          // Overflow: an end pulse in the same cycle closes the dropped frame right away.
          buf_state_d[wr_buf_q] = BUF_FREE;
          if (end_pulse) begin
            cnt_dropped_d = cnt_dropped_q + 32'd1;
            wr_state_d    = WR_IDLE;
          end else begin
            wr_state_d = WR_DROP;
          end
        end else begin
          if (word) begin
            mem_we                 = 1'b1;
            wr_ptr_d               = wr_ptr_q + cnt_t'(1);
            last_valid_d[wr_buf_q] = bus.i_mac_rx_data_valid;
          end
          if (bus.i_mac_rx_good_frame) begin
            buf_state_d[wr_buf_q] = BUF_FULL;
            count_d[wr_buf_q]     = wr_ptr_d;
            newest_d              = wr_buf_q;
            wr_state_d            = WR_IDLE;
          end else if (bus.i_mac_rx_bad_frame) begin
            buf_state_d[wr_buf_q] = BUF_FREE;
            cnt_dropped_d         = cnt_dropped_q + 32'd1;
            wr_state_d            = WR_IDLE;
          end
        end
      end
      WR_DROP: begin
        if (end_pulse) begin
          cnt_dropped_d = cnt_dropped_q + 32'd1;
          wr_state_d    = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    if (presented) begin
      if (bus.i_dispatch_packet_read_discard) begin
        buf_state_d[rd_buf_q] = BUF_FREE;
      end else if (bus.i_dispatch_fifo_rd_en && !empty) begin
        rd_ptr_d = rd_ptr_q + cnt_t'(1);
      end
    end else if (!bus.i_dispatch_packet_read_discard && (full0 || full1)) begin
      // Waiting for discard to drop keeps a held discard from releasing the next frame too.
      buf_state_d[present_sel] = BUF_PRESENTED;
      rd_buf_d                 = present_sel;
      rd_ptr_d                 = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int unsigned i = 0; i < NUM_BUFS; i++) begin
        buf_state_q[i]  <= BUF_FREE;
        count_q[i]      <= '0;
        last_valid_q[i] <= '0;
      end
      wr_state_q    <= WR_IDLE;
      wr_buf_q      <= 1'b0;
      wr_ptr_q      <= '0;
      newest_q      <= 1'b0;
      rd_buf_q      <= 1'b0;
      rd_ptr_q      <= '0;
      cnt_dropped_q <= '0;
    end else begin
      buf_state_q   <= buf_state_d;
      count_q       <= count_d;
      last_valid_q  <= last_valid_d;
      wr_state_q    <= wr_state_d;
      wr_buf_q      <= wr_buf_d;
      wr_ptr_q      <= wr_ptr_d;
      newest_q      <= newest_d;
      rd_buf_q      <= rd_buf_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_dropped_q <= cnt_dropped_d;
    end
  end

  nts_dispatcher_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .i_clk     (i_clk),
    .wr_en_i   (mem_we),
    .wr_buf_i  (mem_wsel),
    .wr_addr_i (mem_waddr),
    .wr_data_i (bus.i_mac_rx_data),
    .rd_buf_i  (rd_buf_q),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (mem_rdata)
  );

  assign bus.o_dispatch_packet_available = presented;
  assign bus.o_dispatch_fifo_empty       = empty;
  assign bus.o_dispatch_data_valid       = presented ? last_valid_q[rd_buf_q] : '0;
  assign bus.o_dispatch_fifo_rd_data     = presented ? mem_rdata : '0;
  assign bus.o_cnt_dropped               = cnt_dropped_q;

endmodule

// File: tb/tb_nts_rx_dispatcher.sv
// Directed bench for nts_rx_dispatcher: frame table plus hand-written multi-cycle sequences.
module tb_nts_rx_dispatcher;

  logic clk = 1'b0;
  logic areset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nts_rx_dispatcher_if bus ();

  nts_rx_dispatcher #(.ADDR_WIDTH(10)) dut (
    .i_clk    (clk),
    .i_areset (areset),
    .bus      (bus)
  );

  typedef struct {
    int         tag;
    int         n;
    logic [7:0] lastv;
    int         kind;      // 1 = good_frame, 2 = bad_frame
    logic       exp_avail;
    int         exp_drop;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [63:0] mk(input int tag, input int idx);
    logic [15:0] t, x;
    t = tag[15:0];
    x = idx[15:0];
    return {t, x, ~t, x ^ 16'h5A5A};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int tag, input int first, input int n,
                            input logic [7:0] lastv, input int kind);
    for (int i = 0; i < n; i++) begin
      bus.i_mac_rx_data_valid = (i == n - 1) ? lastv : 8'hFF;
      bus.i_mac_rx_data       = mk(tag, first + i);
      step();
    end
    bus.i_mac_rx_data_valid = '0;
    bus.i_mac_rx_data       = '0;
    if (kind != 0) begin
      bus.i_mac_rx_good_frame = (kind == 1);
      bus.i_mac_rx_bad_frame  = (kind == 2);
      step();
      bus.i_mac_rx_good_frame = 1'b0;
      bus.i_mac_rx_bad_frame  = 1'b0;
    end
  endtask

  task automatic pop_check(input string name, input int tag, input int first, input int n,
                           input logic [7:0] lastv);
    chk({name, " available"}, 64'(bus.o_dispatch_packet_available), 64'd1);
    chk({name, " data_valid"}, 64'(bus.o_dispatch_data_valid), 64'(lastv));
    bus.i_dispatch_fifo_rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({name, " not empty"}, 64'(bus.o_dispatch_fifo_empty), 64'd0);
      chk({name, " word"}, bus.o_dispatch_fifo_rd_data, mk(tag, first + i));
      step();
    end
    chk({name, " empty after last pop"}, 64'(bus.o_dispatch_fifo_empty), 64'd1);
    step();
    bus.i_dispatch_fifo_rd_en = 1'b0;
    chk({name, " pop on empty ignored"}, 64'(bus.o_dispatch_fifo_empty), 64'd1);
    chk({name, " still available"}, 64'(bus.o_dispatch_packet_available), 64'd1);
  endtask

  task automatic discard_check(input string name);
    bus.i_dispatch_packet_read_discard = 1'b1;
    step();
    bus.i_dispatch_packet_read_discard = 1'b0;
    chk({name, " available after discard"}, 64'(bus.o_dispatch_packet_available), 64'd0);
    chk({name, " empty after discard"}, 64'(bus.o_dispatch_fifo_empty), 64'd1);
  endtask

  task automatic wait_avail(input string name, input int budget);
    int k;
    k = 0;
    while (!bus.o_dispatch_packet_available && k < budget) begin
      step();
      k++;
    end
    chk({name, " presented within budget"}, 64'(bus.o_dispatch_packet_available), 64'd1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset                             = 1'b1;
    bus.i_mac_rx_data_valid            = '0;
    bus.i_mac_rx_data                  = '0;
    bus.i_mac_rx_good_frame            = 1'b0;
    bus.i_mac_rx_bad_frame             = 1'b0;
    bus.i_dispatch_packet_read_discard = 1'b0;
    bus.i_dispatch_fifo_rd_en          = 1'b0;

    vecs[0] = '{tag: 1, n: 8, lastv: 8'h0F, kind: 1, exp_avail: 1'b1, exp_drop: 0};
    vecs[1] = '{tag: 2, n: 1, lastv: 8'h80, kind: 1, exp_avail: 1'b1, exp_drop: 0};
    vecs[2] = '{tag: 3, n: 5, lastv: 8'hFF, kind: 2, exp_avail: 1'b0, exp_drop: 1};
    vecs[3] = '{tag: 4, n: 3, lastv: 8'h01, kind: 1, exp_avail: 1'b1, exp_drop: 1};
    vecs[4] = '{tag: 5, n: 2, lastv: 8'h3C, kind: 2, exp_avail: 1'b0, exp_drop: 2};

    step();
    chk("reset available", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("reset empty", 64'(bus.o_dispatch_fifo_empty), 64'd1);
    chk("reset data_valid", 64'(bus.o_dispatch_data_valid), 64'd0);
    chk("reset rd_data", bus.o_dispatch_fifo_rd_data, 64'd0);
    chk("reset dropped", 64'(bus.o_cnt_dropped), 64'd0);
    step();
    areset = 1'b0;
    step();

    // Single frames: good frames read and discarded, bad frames dropped.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].tag, 0, vecs[v].n, vecs[v].lastv, vecs[v].kind);
      step();
      chk($sformatf("vec%0d available", v), 64'(bus.o_dispatch_packet_available),
          64'(vecs[v].exp_avail));
      chk($sformatf("vec%0d dropped", v), 64'(bus.o_cnt_dropped), 64'(vecs[v].exp_drop));
      if (vecs[v].exp_avail) begin
        pop_check($sformatf("vec%0d", v), vecs[v].tag, 0, vecs[v].n, vecs[v].lastv);
        discard_check($sformatf("vec%0d", v));
      end else begin
        chk($sformatf("vec%0d empty", v), 64'(bus.o_dispatch_fifo_empty), 64'd1);
      end
    end

    // Held discard releases only the presented frame; the second one survives intact.
    do_reset();
    send_frame(10, 0, 4, 8'hF0, 1);
    send_frame(11, 0, 3, 8'h07, 1);
    step();
    chk("held first available", 64'(bus.o_dispatch_packet_available), 64'd1);
    chk("held first word", bus.o_dispatch_fifo_rd_data, mk(10, 0));
    bus.i_dispatch_packet_read_discard = 1'b1;
    step();
    chk("held discard available low", 64'(bus.o_dispatch_packet_available), 64'd0);
    step();
    step();
    bus.i_dispatch_packet_read_discard = 1'b0;
    wait_avail("held second", 4);
    pop_check("held second", 11, 0, 3, 8'h07);
    discard_check("held second");
    step();
    step();
    chk("held nothing left", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("held dropped", 64'(bus.o_cnt_dropped), 64'd0);

    // Three back-to-back frames with a stalled engine: third is dropped, order kept.
    do_reset();
    send_frame(20, 0, 4, 8'hFF, 1);
    send_frame(21, 0, 4, 8'h1F, 1);
    send_frame(22, 0, 4, 8'h03, 1);
    step();
    chk("b2b dropped", 64'(bus.o_cnt_dropped), 64'd1);
    pop_check("b2b frame1", 20, 0, 4, 8'hFF);
    discard_check("b2b frame1");
    wait_avail("b2b frame2", 4);
    pop_check("b2b frame2", 21, 0, 4, 8'h1F);
    discard_check("b2b frame2");
    step();
    step();
    chk("b2b frame3 absent", 64'(bus.o_dispatch_packet_available), 64'd0);

    // Overlong frame dropped; a full-size frame plus another frame then both fit.
    do_reset();
    send_frame(30, 0, 1025, 8'hFF, 1);
    step();
    chk("overflow available", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("overflow dropped", 64'(bus.o_cnt_dropped), 64'd1);
    send_frame(31, 0, 1024, 8'hFF, 1);
    send_frame(32, 0, 3, 8'h0E, 1);
    step();
    chk("fullsize dropped unchanged", 64'(bus.o_cnt_dropped), 64'd1);
    pop_check("fullsize", 31, 0, 1024, 8'hFF);
    discard_check("fullsize");
    wait_avail("after fullsize", 4);
    pop_check("after fullsize", 32, 0, 3, 8'h0E);
    discard_check("after fullsize");

    // Reset with one frame presented and another filling; the tail arrives as a new frame.
    do_reset();
    send_frame(50, 0, 2, 8'hFF, 2);
    step();
    chk("midreset pre dropped", 64'(bus.o_cnt_dropped), 64'd1);
    send_frame(40, 0, 4, 8'h0F, 1);
    step();
    chk("midreset presented", 64'(bus.o_dispatch_packet_available), 64'd1);
    send_frame(41, 0, 3, 8'hFF, 0);
    areset = 1'b1;
    #1;
    chk("midreset available", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("midreset empty", 64'(bus.o_dispatch_fifo_empty), 64'd1);
    chk("midreset data_valid", 64'(bus.o_dispatch_data_valid), 64'd0);
    chk("midreset rd_data", bus.o_dispatch_fifo_rd_data, 64'd0);
    chk("midreset dropped", 64'(bus.o_cnt_dropped), 64'd0);
    step();
    areset = 1'b0;
    step();
    send_frame(41, 3, 2, 8'h03, 1);
    step();
    pop_check("tail frame", 41, 3, 2, 8'h03);
    discard_check("tail frame");
    send_frame(42, 0, 6, 8'hC0, 1);
    step();
    pop_check("post reset", 42, 0, 6, 8'hC0);
    discard_check("post reset");
    chk("post reset dropped", 64'(bus.o_cnt_dropped), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
